// File: rtl/regbank_pkg.sv
// regbank_pkg
//   Shared definitions for the register-bank write scheduler: the default
//   register bank geometry, the hardwired-zero register address and the
//   scheduler state type.
package regbank_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Register 0 always reads zero, so writes to it are never forwarded.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // CLEAR walks the bank writing zeros; ARB shares the port among requesters.
    typedef enum logic {
        ST_CLEAR,
        ST_ARB
    } state_t;

endpackage

// File: rtl/regbank_write_scheduler_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. The search for a requester
//   starts at ptr and wraps modulo NUM_REQ; the first requester found
//   wins.
//
// Ports
//   req        in   NUM_REQ   request vector
//   ptr        in   IDX_W     highest-priority requester this cycle
//   grant      out  NUM_REQ   one-hot grant, all zero when req is zero
//   grant_idx  out  IDX_W     index of the granted requester (0 when none)
module rr_arbiter #(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Walk the requesters in priority order starting at ptr; found
    // latches the first hit so later candidates are ignored.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regbank_write_scheduler.sv
// regbank_write_scheduler
//   Owns the single write port of the register bank. After reset it writes
//   zero to registers 0..NUM_REGS-1, one per cycle, then shares the port
//   among NUM_REQ writeback requesters with round-robin arbitration.
//   Accepted writes appear on the port one cycle after acceptance.
//
// Ports
//   clock      in   1                 system clock
//   reset      in   1                 synchronous active-high reset
//   req_valid  in   NUM_REQ           requester i presents a write
//   req_addr   in   NUM_REQ*ADDR_W    requester i target at [i*ADDR_W +: ADDR_W]
//   req_data   in   NUM_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ           one-hot acceptance (combinational)
//   RegC       out  ADDR_W            bank write address
//   WriteData  out  DATA_W            bank write data
//   RegWrite   out  1                 bank write enable
//   clearing   out  1                 high while the clear sequence is on the port
//   grant_id   out  clog2(NUM_REQ)    requester owning the current write
module regbank_write_scheduler
    import regbank_pkg::*;
#(
    parameter  int NUM_REQ  = 3,
    parameter  int DATA_W   = REG_DATA_W,
    parameter  int ADDR_W   = REG_ADDR_W,
    parameter  int NUM_REGS = regbank_pkg::NUM_REGS,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]           RegC,
    output logic [DATA_W-1:0]           WriteData,
    output logic                        RegWrite,
    output logic                        clearing,
    output logic [IDX_W-1:0]            grant_id
);

    // One extra bit so the counter can reach NUM_REGS, marking that every
    // clear write has already been put on the port.
    localparam int CNT_W = ADDR_W + 1;

    state_t             state;
    logic [CNT_W-1:0]   clear_cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               accept;
    logic               zero_target;
    logic [IDX_W-1:0]   next_ptr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Requesters only see ready once the clear has finished; the bank port
    // is never back-pressured, so the arbiter result is the handshake.
    assign req_ready   = (state == ST_ARB) ? arb_grant : '0;
    assign accept      = |req_ready;
    assign zero_target = (sel_addr == ADDR_W'(ZERO_REG));
    assign next_ptr    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

    // Steer the granted requester's address and data onto a single bus.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scheduler FSM with registered port outputs. In CLEAR the counter
    // issues one zero write per cycle; the edge after the last clear write
    // leaves CLEAR and drops clearing together. In ARB an accepted request
    // is registered onto the port, except writes to register 0, which are
    // accepted but never raise RegWrite.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clear_cnt <= '0;
            rr_ptr    <= '0;
            RegC      <= '0;
            WriteData <= '0;
            RegWrite  <= 1'b0;
            clearing  <= 1'b1;
            grant_id  <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_cnt == CNT_W'(NUM_REGS)) begin
                        state    <= ST_ARB;
                        clearing <= 1'b0;
                        RegWrite <= 1'b0;
                    end else begin
                        RegWrite  <= 1'b1;
                        RegC      <= clear_cnt[ADDR_W-1:0];
                        WriteData <= '0;
                        clear_cnt <= clear_cnt + CNT_W'(1);
                    end
                end
                ST_ARB: begin
                    RegWrite <= accept && !zero_target;
                    if (accept) begin
                        rr_ptr <= next_ptr;
                        if (!zero_target) begin
                            RegC      <= sel_addr;
                            WriteData <= sel_data;
                            grant_id  <= arb_idx;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// tb_regbank_write_scheduler
//   Scenario tasks for the register-bank write scheduler, finishing with a
//   randomized run checked against a queue-free behavioural model that
//   tracks pending requests and the round-robin pointer.
module tb_regbank_write_scheduler;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int IW = $clog2(N);

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     RegC;
    logic [DW-1:0]     WriteData;
    logic              RegWrite;
    logic              clearing;
    logic [IW-1:0]     grant_id;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    logic [DW-1:0] bank [32];

    regbank_write_scheduler #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .RegC      (RegC),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .clearing  (clearing),
        .grant_id  (grant_id)
    );

    always #5 clock = ~clock;

    // Register bank as the DUT's write port would update it.
    always @(posedge clock) begin
        if (RegWrite) bank[RegC] <= WriteData;
    end

    // Guard against an unexpected hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired, required finish before 200000");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_addr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]   = d;
    endtask

    // Round-robin rule: first valid requester at or after ptr, wrapping.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_regwrite: got %0b expected 0", RegWrite); end
        checks++;
        if (clearing !== 1'b1) begin failures++; $display("[TB] FAIL reset_clearing: got %0b expected 1", clearing); end
        checks++;
        if (RegC !== '0 || WriteData !== '0 || grant_id !== '0) begin
            failures++;
            $display("[TB] FAIL reset_port: got RegC=%0h WriteData=%0h grant_id=%0h expected all 0", RegC, WriteData, grant_id);
        end
        checks++;
        if (req_ready !== '0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 000", req_ready); end
    endtask

    // Releases reset at the current negedge and checks the full clear walk.
    task automatic check_clear_walk(input string tag);
        reset = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clock);
            checks++;
            if (RegWrite !== 1'b1 || RegC !== AW'(c) || WriteData !== '0 || clearing !== 1'b1 || req_ready !== '0) begin
                failures++;
                $display("[TB] FAIL %s_cycle%0d: got we=%0b RegC=%0d data=%0h clearing=%0b ready=%b expected we=1 RegC=%0d data=0 clearing=1 ready=000",
                         tag, c, RegWrite, RegC, WriteData, clearing, req_ready, c);
            end
        end
        @(negedge clock);
        checks++;
        if (clearing !== 1'b0 || RegWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_done: got clearing=%0b we=%0b expected clearing=0 we=0", tag, clearing, RegWrite);
        end
        m_ptr = 0;
    endtask

    task automatic test_clear_sequence();
        check_clear_walk("clear");
        checks++;
        if (req_ready !== 3'b001) begin failures++; $display("[TB] FAIL clear_first_ready: got %b expected 001", req_ready); end
        @(negedge clock);
        req_valid = '0;
        checks++;
        if (RegWrite !== 1'b1 || grant_id !== 2'd0 || RegC !== 5'd1 || WriteData !== 32'h100) begin
            failures++;
            $display("[TB] FAIL clear_first_grant: got we=%0b id=%0d RegC=%0d data=%0h expected we=1 id=0 RegC=1 data=100",
                     RegWrite, grant_id, RegC, WriteData);
        end
        m_ptr = 1;
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL clear_idle: got we=%0b expected 0", RegWrite); end
    endtask

    task automatic test_single_requester();
        req_valid = '0;
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        checks++;
        if (req_ready !== 3'b010) begin failures++; $display("[TB] FAIL single_ready: got %b expected 010", req_ready); end
        @(negedge clock);
        req_valid = '0;
        checks++;
        if (RegWrite !== 1'b1 || RegC !== 5'd7 || WriteData !== 32'hDEADBEEF || grant_id !== 2'd1) begin
            failures++;
            $display("[TB] FAIL single_write: got we=%0b RegC=%0d data=%0h id=%0d expected we=1 RegC=7 data=deadbeef id=1",
                     RegWrite, RegC, WriteData, grant_id);
        end
        m_ptr = 2;
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL single_idle: got we=%0b expected 0", RegWrite); end
    endtask

    task automatic test_zero_register();
        req_valid = '0;
        set_req(2, 1'b1, 5'd0, 32'h1234);
        #1;
        checks++;
        if (req_ready !== 3'b100) begin failures++; $display("[TB] FAIL zero_ready: got %b expected 100", req_ready); end
        @(negedge clock);
        req_valid = '0;
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL zero_suppress: got we=%0b expected 0", RegWrite); end
        m_ptr = 0;
        // Contention probe only: valid is withdrawn before the clock edge.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(20 + i), DW'(i));
        #1;
        checks++;
        if (req_ready !== 3'b001) begin failures++; $display("[TB] FAIL zero_next_winner: got %b expected 001", req_ready); end
        #1;
        req_valid = '0;
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL zero_probe_idle: got we=%0b expected 0", RegWrite); end
    endtask

    task automatic test_round_robin();
        int exp_g;
        int prev_g;
        prev_g = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(10 + i), 32'hA000_0000 + DW'(i));
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                @(negedge clock);
                checks++;
                if (RegWrite !== 1'b1 || grant_id !== IW'(prev_g) || RegC !== AW'(10 + prev_g) ||
                    WriteData !== 32'hA000_0000 + DW'(prev_g)) begin
                    failures++;
                    $display("[TB] FAIL rr_write%0d: got we=%0b id=%0d RegC=%0d data=%0h expected we=1 id=%0d RegC=%0d",
                             k - 1, RegWrite, grant_id, RegC, WriteData, prev_g, 10 + prev_g);
                end
            end
            if (k < 6) begin
                #1;
                exp_g = pick(req_valid, m_ptr);
                checks++;
                if (req_ready !== onehot(exp_g) || exp_g != (k % N)) begin
                    failures++;
                    $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, req_ready, onehot(k % N));
                end
                prev_g = exp_g;
                m_ptr  = (exp_g + 1) % N;
            end else begin
                req_valid = '0;
            end
        end
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL rr_idle: got we=%0b expected 0", RegWrite); end
    endtask

    task automatic test_back_to_back();
        req_valid = '0;
        set_req(0, 1'b1, 5'd4, 32'd1);
        set_req(1, 1'b1, 5'd4, 32'd2);
        #1;
        checks++;
        if (req_ready !== 3'b001) begin failures++; $display("[TB] FAIL b2b_ready0: got %b expected 001", req_ready); end
        @(negedge clock);
        req_valid[0] = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || RegC !== 5'd4 || WriteData !== 32'd1 || grant_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL b2b_first: got we=%0b RegC=%0d data=%0h id=%0d expected we=1 RegC=4 data=1 id=0",
                     RegWrite, RegC, WriteData, grant_id);
        end
        #1;
        checks++;
        if (req_ready !== 3'b010) begin failures++; $display("[TB] FAIL b2b_ready1: got %b expected 010", req_ready); end
        @(negedge clock);
        req_valid = '0;
        checks++;
        if (RegWrite !== 1'b1 || RegC !== 5'd4 || WriteData !== 32'd2 || grant_id !== 2'd1) begin
            failures++;
            $display("[TB] FAIL b2b_second: got we=%0b RegC=%0d data=%0h id=%0d expected we=1 RegC=4 data=2 id=1",
                     RegWrite, RegC, WriteData, grant_id);
        end
        m_ptr = 2;
        @(negedge clock);
        checks++;
        if (bank[4] !== 32'd2) begin failures++; $display("[TB] FAIL b2b_bank: got reg4=%0h expected 2", bank[4]); end
    endtask

    task automatic test_reset_mid();
        req_valid = '0;
        set_req(1, 1'b1, 5'd9, 32'hCAFE_0009);
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin failures++; $display("[TB] FAIL rst_mid_ready: got %b expected 010", req_ready); end
        @(negedge clock);
        req_valid = '0;
        checks++;
        if (RegWrite !== 1'b0 || clearing !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_held1: got we=%0b clearing=%0b expected we=0 clearing=1", RegWrite, clearing);
        end
        @(negedge clock);
        checks++;
        if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_held2: got we=%0b expected 0", RegWrite); end
        check_clear_walk("rst_mid");
    endtask

    task automatic test_random();
        logic              pend [N];
        logic [AW-1:0]     pa   [N];
        logic [DW-1:0]     pd   [N];
        logic [N-1:0]      pv;
        logic              exp_we;
        logic [AW-1:0]     exp_addr;
        logic [DW-1:0]     exp_data;
        int                exp_id;
        int                g;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_id   = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            pd[i]   = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clock);
            checks++;
            if (RegWrite !== exp_we) begin
                failures++;
                $display("[TB] FAIL rand_we_c%0d: got %0b expected %0b", cyc, RegWrite, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (RegC !== exp_addr || WriteData !== exp_data || grant_id !== IW'(exp_id)) begin
                    failures++;
                    $display("[TB] FAIL rand_port_c%0d: got RegC=%0d data=%0h id=%0d expected RegC=%0d data=%0h id=%0d",
                             cyc, RegC, WriteData, grant_id, exp_addr, exp_data, exp_id);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i]   = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
                    pd[i]   = $urandom;
                end
                set_req(i, pend[i], pa[i], pd[i]);
                pv[i] = pend[i];
            end
            #1;
            g = pick(pv, m_ptr);
            checks++;
            if (req_ready !== onehot(g)) begin
                failures++;
                $display("[TB] FAIL rand_ready_c%0d: got %b expected %b", cyc, req_ready, onehot(g));
            end
            if (g >= 0) begin
                exp_we   = (pa[g] != '0);
                exp_addr = pa[g];
                exp_data = pd[g];
                exp_id   = g;
                m_ptr    = (g + 1) % N;
                pend[g]  = 1'b0;
            end else begin
                exp_we = 1'b0;
            end
        end
        @(negedge clock);
        req_valid = '0;
        checks++;
        if (RegWrite !== exp_we) begin failures++; $display("[TB] FAIL rand_last_we: got %0b expected %0b", RegWrite, exp_we); end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_clear_sequence();
        test_single_requester();
        test_zero_register();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
